// File: rtl/dm_copy_engine_if.sv
// Bundles the CPU request side and the data-memory initiator side of the copy engine.
// The engine connects through master; the CPU/memory environment uses slave.
interface dm_copy_engine_if #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 16,
    parameter int LEN_SIZE   = 8
);
    logic                  start;
    logic                  mode;
    logic [SELEC_SIZE-1:0] src_addr;
    logic [SELEC_SIZE-1:0] dst_addr;
    logic [LEN_SIZE-1:0]   len;
    logic [DATA_SIZE-1:0]  fill_value;
    logic                  busy;
    logic                  done;
    logic                  dm_we;
    logic [SELEC_SIZE-1:0] dm_address;
    logic [DATA_SIZE-1:0]  dm_d;
    logic [DATA_SIZE-1:0]  dm_q;

    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_value, dm_q,
        output busy, done, dm_we, dm_address, dm_d
    );

    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_value, dm_q,
        input  busy, done, dm_we, dm_address, dm_d
    );
endinterface

// File: rtl/dm_copy_engine.sv
// Simple DMA beside the CPU: block copy (src->dst) or block fill of len words
// through the single-port data memory, ascending addresses with modulo wrap.
module dm_copy_engine #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 16,
    parameter int LEN_SIZE   = 8
) (
    input  logic             clk,
    input  logic             rst,
    dm_copy_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  mode_r;
    logic [SELEC_SIZE-1:0] src_ptr;
    logic [SELEC_SIZE-1:0] dst_ptr;
    logic [LEN_SIZE-1:0]   count;
    logic [DATA_SIZE-1:0]  data_r;
    logic [DATA_SIZE-1:0]  fill_r;

    // Request fields are snapshotted on acceptance so the CPU may change them while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_r  <= '0;
            fill_r  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_r  <= bus.mode;
                        src_ptr <= bus.src_addr;
                        dst_ptr <= bus.dst_addr;
                        count   <= bus.len;
                        fill_r  <= bus.fill_value;
                    end
                end
                READ: begin
                    data_r  <= bus.dm_q;
                    src_ptr <= src_ptr + SELEC_SIZE'(1);
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + SELEC_SIZE'(1);
                    count   <= count - LEN_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    // Memory outputs decode only from registered state, so dm_we cannot glitch.
    always_comb begin
        state_nxt      = state;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_address = '0;
        bus.dm_d       = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0)
                        state_nxt = DONE;
                    else if (bus.mode)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                bus.busy       = 1'b1;
                bus.dm_address = src_ptr;
                state_nxt      = WRITE;
            end
            WRITE: begin
                bus.busy       = 1'b1;
                bus.dm_we      = 1'b1;
                bus.dm_address = dst_ptr;
                bus.dm_d       = mode_r ? fill_r : data_r;
                if (count == LEN_SIZE'(1))
                    state_nxt = DONE;
                else if (mode_r)
                    state_nxt = WRITE;
                else
                    state_nxt = READ;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine: behavioural data memory plus a write scoreboard
// fed by a reference copy/fill model over a shadow memory.
module tb_dm_copy_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dm_copy_engine_if bus ();

    dm_copy_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [15:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int checks    = 0;
    int failures  = 0;
    int we_pulses = 0;

    assign bus.dm_q = mem[bus.dm_address];

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {~a, a} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each DUT write is matched against the oldest model write, then committed to memory.
    always @(negedge clk) begin
        if (bus.dm_we === 1'b1) begin
            we_pulses++;
            if (exp_addr.size() == 0) begin
                checkOutput("unexpected_write", 64'(1), 64'(0));
            end else begin
                checkOutput("wr_addr", 64'(bus.dm_address), 64'(exp_addr.pop_front()));
                checkOutput("wr_data", 64'(bus.dm_d), 64'(exp_data.pop_front()));
            end
            mem[bus.dm_address] = bus.dm_d;
        end
    end

    task automatic applyStimulus(input string tag, input logic m, input logic [15:0] s,
                                 input logic [15:0] d, input logic [7:0] n,
                                 input logic [31:0] f, input bit scramble, input int rst_cycle);
        int          exp_done;
        int          nw;
        int          done_cycle;
        int          done_cnt;
        int          busy_cnt;
        int          we_start;
        logic [15:0] wa;
        logic [31:0] wd;

        exp_done = (n == 8'd0) ? 1 : (m ? int'(n) + 1 : 2 * int'(n) + 1);
        nw = int'(n);
        if (rst_cycle > 0) begin
            nw = m ? rst_cycle : rst_cycle / 2;
            if (nw > int'(n)) nw = int'(n);
        end
        for (int i = 0; i < nw; i++) begin
            wa = d + 16'(i);
            wd = m ? f : ref_mem[s + 16'(i)];
            ref_mem[wa] = wd;
            exp_addr.push_back(wa);
            exp_data.push_back(wd);
        end

        done_cycle = 0;
        done_cnt   = 0;
        busy_cnt   = 0;
        we_start   = we_pulses;

        @(negedge clk);
        bus.mode       = m;
        bus.src_addr   = s;
        bus.dst_addr   = d;
        bus.len        = n;
        bus.fill_value = f;
        bus.start      = 1'b1;

        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cycle == 0) done_cycle = c;
            end
            if (scramble && c >= 2 && c <= 4) begin
                bus.start      = 1'b1;
                bus.mode       = ~m;
                bus.src_addr   = ~s;
                bus.dst_addr   = d + 16'h7;
                bus.len        = n + 8'd3;
                bus.fill_value = ~f;
            end
            if (rst_cycle != 0 && c == rst_cycle) begin
                rst = 1'b1;
                @(negedge clk);
                checkOutput({tag, "_rst_busy"}, 64'(bus.busy), 64'(0));
                checkOutput({tag, "_rst_we"}, 64'(bus.dm_we), 64'(0));
                checkOutput({tag, "_rst_addr"}, 64'(bus.dm_address), 64'(0));
                checkOutput({tag, "_rst_done"}, 64'(bus.done), 64'(0));
                rst = 1'b0;
                break;
            end
        end

        #1;
        if (rst_cycle == 0) begin
            checkOutput({tag, "_done_cycle"}, 64'(done_cycle), 64'(exp_done));
            checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
            checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_done));
        end
        checkOutput({tag, "_we_pulses"}, 64'(we_pulses - we_start), 64'(nw));
        checkOutput({tag, "_sb_leftover"}, 64'(exp_addr.size()), 64'(0));
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = pat(16'(i));
            ref_mem[i] = pat(16'(i));
        end
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.len        = '0;
        bus.fill_value = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'(0));
        checkOutput("reset_done", 64'(bus.done), 64'(0));
        checkOutput("reset_we", 64'(bus.dm_we), 64'(0));
        checkOutput("reset_addr", 64'(bus.dm_address), 64'(0));
        checkOutput("reset_d", 64'(bus.dm_d), 64'(0));
        rst = 1'b0;

        $display("[TB] block copy 0x10 -> 0x40, 4 words");
        applyStimulus("copy", 1'b0, 16'h0010, 16'h0040, 8'd4, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            checkOutput("copy_mem", 64'(mem[16'h0040 + 16'(i)]), 64'(pat(16'h0010 + 16'(i))));

        $display("[TB] block fill 0x20, 3 words");
        applyStimulus("fill", 1'b1, 16'h0000, 16'h0020, 8'd3, 32'hDEAD_BEEF, 1'b0, 0);
        for (int i = 0; i < 3; i++)
            checkOutput("fill_mem", 64'(mem[16'h0020 + 16'(i)]), 64'(32'hDEAD_BEEF));
        checkOutput("fill_guard", 64'(mem[16'h0023]), 64'(pat(16'h0023)));

        $display("[TB] zero-length requests");
        applyStimulus("copy_len0", 1'b0, 16'h0010, 16'h0060, 8'd0, 32'h0, 1'b0, 0);
        applyStimulus("fill_len0", 1'b1, 16'h0000, 16'h0060, 8'd0, 32'hCAFE_F00D, 1'b0, 0);
        checkOutput("len0_guard", 64'(mem[16'h0060]), 64'(pat(16'h0060)));

        $display("[TB] source wrap across 0xFFFF");
        applyStimulus("wrap", 1'b0, 16'hFFFE, 16'h0100, 8'd4, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            checkOutput("wrap_mem", 64'(mem[16'h0100 + 16'(i)]), 64'(pat(16'hFFFE + 16'(i))));

        $display("[TB] inputs disturbed while busy");
        applyStimulus("scramble", 1'b0, 16'h0010, 16'h0080, 8'd4, 32'h1234_5678, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            checkOutput("scramble_mem", 64'(mem[16'h0080 + 16'(i)]), 64'(pat(16'h0010 + 16'(i))));
        checkOutput("scramble_guard", 64'(mem[16'h0087]), 64'(pat(16'h0087)));

        $display("[TB] overlapping forward copy");
        applyStimulus("overlap", 1'b0, 16'h0050, 16'h0051, 8'd4, 32'h0, 1'b0, 0);
        for (int i = 1; i <= 4; i++)
            checkOutput("overlap_mem", 64'(mem[16'h0050 + 16'(i)]), 64'(pat(16'h0050)));

        $display("[TB] reset during an 8-word copy");
        applyStimulus("abort", 1'b0, 16'h0200, 16'h0300, 8'd8, 32'h0, 1'b0, 3);
        checkOutput("abort_word0", 64'(mem[16'h0300]), 64'(pat(16'h0200)));
        checkOutput("abort_word1", 64'(mem[16'h0301]), 64'(pat(16'h0301)));
        applyStimulus("restart", 1'b0, 16'h0200, 16'h0300, 8'd8, 32'h0, 1'b0, 0);
        for (int i = 0; i < 8; i++)
            checkOutput("restart_mem", 64'(mem[16'h0300 + 16'(i)]), 64'(pat(16'h0200 + 16'(i))));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
